// File: rtl/dac_pkg.sv
// Shared types and frame helpers for the multi-channel DAC frame serializer.
package dac_pkg;

  localparam int FRAME_W      = 16;
  localparam int DATA_FIELD_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10
  } state_t;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  // Frame layout on the wire: two zero control bits, power-down mode, data field.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [1:0]              pd,
    input logic [DATA_FIELD_W-1:0] field
  );
    return {2'b00, pd, field};
  endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// SCLK divider: idles high, toggles every CLK_DIV/2 enabled cycles, and flags
// the cycle before each transition so the caller can act on the same edge.
module dac_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise_tick,
  output logic o_fall_tick
);

  localparam int HALF  = CLK_DIV / 2;
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_sclk;
  logic             w_wrap;

  assign w_wrap      = i_en && (r_cnt == CNT_W'(HALF - 1));
  assign o_rise_tick = w_wrap && !r_sclk;
  assign o_fall_tick = w_wrap && r_sclk;
  assign o_sclk      = r_sclk;

  // Half-period counter and SCLK level; a clear restarts the phase from high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b1;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_sclk <= 1'b1;
    end else if (i_en) begin
      if (w_wrap) begin
        r_cnt  <= '0;
        r_sclk <= ~r_sclk;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_sclk <= r_sclk;
      end
    end else begin
      r_cnt  <= r_cnt;
      r_sclk <= r_sclk;
    end
  end

endmodule

// File: rtl/dac_frame_serializer.sv
// Parallel-in, multi-channel 16-bit DAC frame serializer with SYNC-aligned
// frames, internally generated SCLK and a minimum inter-frame gap.
module dac_frame_serializer
  import dac_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int NUM_CH  = 1,
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  input  logic [1:0]               s_pd,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     SCLK,
  output logic                     SYNC,
  output logic [NUM_CH-1:0]        DATA,
  output logic                     frame_done
);

  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam int SH_W  = NUM_CH * FRAME_W;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_bit;
  logic [3:0]        w_bit_nxt;
  logic [SH_W-1:0]   r_shreg;
  logic [SH_W-1:0]   w_shreg_nxt;
  logic [GAP_W-1:0]  r_gap;
  logic [GAP_W-1:0]  w_gap_nxt;
  logic              r_sync;
  logic              w_sync_nxt;
  logic [NUM_CH-1:0] r_data;
  logic [NUM_CH-1:0] w_data_nxt;
  logic              r_ready;
  logic              w_ready_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic [SH_W-1:0]   w_frames;
  logic              w_accept;
  logic              w_sclk;
  logic              w_rise_tick;
  logic              w_fall_tick;

  assign w_accept   = (r_state == IDLE) && s_valid && r_ready;
  assign s_ready    = r_ready;
  assign SYNC       = r_sync;
  assign DATA       = r_data;
  assign frame_done = r_done;
  assign SCLK       = w_sclk;

  dac_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_accept),
    .i_en        (r_state == SHIFT),
    .o_sclk      (w_sclk),
    .o_rise_tick (w_rise_tick),
    .o_fall_tick (w_fall_tick)
  );

  // Left-justify each channel's sample into the data field and build its frame.
  always_comb begin
    w_frames = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_frames[c*FRAME_W +: FRAME_W] = build_frame(
        s_pd, DATA_FIELD_W'(s_data[c*DATA_W +: DATA_W]) << (DATA_FIELD_W - DATA_W));
    end
  end

  // Next-state and next-output logic for the IDLE/SHIFT/GAP sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_shreg_nxt = r_shreg;
    w_gap_nxt   = r_gap;
    w_sync_nxt  = r_sync;
    w_data_nxt  = r_data;
    w_ready_nxt = r_ready;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_valid && r_ready) begin
          // First bit goes out with the SYNC falling edge, not one SCLK later.
          w_state_nxt = SHIFT;
          w_shreg_nxt = w_frames;
          w_bit_nxt   = 4'd0;
          w_sync_nxt  = 1'b0;
          w_ready_nxt = 1'b0;
          for (int c = 0; c < NUM_CH; c++) begin
            w_data_nxt[c] = w_frames[c*FRAME_W + FRAME_W - 1];
          end
        end else begin
          w_ready_nxt = 1'b1;
        end
      end
      SHIFT: begin
        if (w_rise_tick) begin
          if (r_bit == 4'd15) begin
            w_state_nxt = GAP;
            w_bit_nxt   = 4'd0;
            w_sync_nxt  = 1'b1;
            w_data_nxt  = '0;
            w_done_nxt  = 1'b1;
            w_gap_nxt   = '0;
          end else begin
            w_bit_nxt = r_bit + 4'd1;
            for (int c = 0; c < NUM_CH; c++) begin
              w_shreg_nxt[c*FRAME_W +: FRAME_W] = {r_shreg[c*FRAME_W +: FRAME_W-1], 1'b0};
              w_data_nxt[c] = r_shreg[c*FRAME_W + FRAME_W - 2];
            end
          end
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      GAP: begin
        if (r_gap == GAP_W'(GAP_CYC - 1)) begin
          w_state_nxt = IDLE;
          w_ready_nxt = 1'b1;
          w_gap_nxt   = '0;
        end else begin
          w_gap_nxt = r_gap + GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_sync_nxt  = 1'b1;
        w_data_nxt  = '0;
        w_ready_nxt = 1'b0;
        w_bit_nxt   = 4'd0;
        w_gap_nxt   = '0;
      end
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_bit   <= 4'd0;
      r_shreg <= '0;
      r_gap   <= '0;
      r_sync  <= 1'b1;
      r_data  <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_shreg <= w_shreg_nxt;
      r_gap   <= w_gap_nxt;
      r_sync  <= w_sync_nxt;
      r_data  <= w_data_nxt;
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_dac_frame_serializer.sv
// Self-checking bench: table vectors, random samples against a frame model,
// back-to-back timing and mid-frame reset recovery.
module tb_dac_frame_serializer;

  localparam int DW  = 8;
  localparam int NCH = 2;
  localparam int CD  = 4;
  localparam int GC  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH*DW-1:0] s_data;
  logic [1:0]        s_pd;
  logic              s_valid;
  logic              s_ready;
  logic              SCLK;
  logic              SYNC;
  logic [NCH-1:0]    DATA;
  logic              frame_done;

  dac_frame_serializer #(
    .DATA_W  (DW),
    .NUM_CH  (NCH),
    .CLK_DIV (CD),
    .GAP_CYC (GC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_pd       (s_pd),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .SCLK       (SCLK),
    .SYNC       (SYNC),
    .DATA       (DATA),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] f0;
    logic [15:0] f1;
    int          len;
    int          falls;
    logic        done;
  } rec_t;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  pd;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  rec_t mon_q[$];
  int   sync_fall_q[$];
  int   done_cnt = 0;
  int   rdy_cnt = 0;
  int   m_len = 0;
  int   m_falls = 0;
  logic [15:0] m_cap0 = '0;
  logic [15:0] m_cap1 = '0;
  logic p_sclk = 1'b1;
  logic p_sync = 1'b1;
  int   frames_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the serial bus as a DAC would: capture DATA on SCLK falling edges.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_len   <= 0;
      m_falls <= 0;
      m_cap0  <= '0;
      m_cap1  <= '0;
      p_sclk  <= 1'b1;
      p_sync  <= 1'b1;
    end else begin
      if (!SYNC) m_len <= m_len + 1;
      if (p_sclk && !SCLK) begin
        m_cap0  <= {m_cap0[14:0], DATA[0]};
        m_cap1  <= {m_cap1[14:0], DATA[1]};
        m_falls <= m_falls + 1;
      end
      if (!p_sync && SYNC) begin
        mon_q.push_back('{f0: m_cap0, f1: m_cap1, len: m_len, falls: m_falls, done: frame_done});
        m_len   <= 0;
        m_falls <= 0;
      end
      if (p_sync && !SYNC) sync_fall_q.push_back(cyc);
      if (frame_done) done_cnt <= done_cnt + 1;
      if (s_ready) rdy_cnt <= rdy_cnt + 1;
      p_sclk <= SCLK;
      p_sync <= SYNC;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected end before 500us");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_frame(input logic [1:0] pd, input int sample);
    return 16'((int'(pd) * 4096) + sample * (1 << (12 - DW)));
  endfunction

  task automatic send(input logic [15:0] d, input logic [1:0] pd);
    int k;
    @(negedge clk);
    s_data  = d;
    s_pd    = pd;
    s_valid = 1'b1;
    for (k = 0; k < 200; k++) begin
      if (s_ready) break;
      @(negedge clk);
    end
    if (k == 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: got s_ready low for 200 cycles, expected high");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = ~d;
    s_pd    = ~pd;
  endtask

  task automatic wait_rec(output rec_t r, output bit ok);
    ok = 1'b0;
    r  = '0;
    for (int k = 0; k < 400; k++) begin
      if (mon_q.size() > 0) begin
        r  = mon_q.pop_front();
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL rec_timeout: got no frame, expected one within 400 cycles");
    end else begin
      frames_seen++;
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] e0, input logic [15:0] e1);
    rec_t r;
    bit   ok;
    wait_rec(r, ok);
    if (ok) begin
      check({tag, "_ch0"}, 32'(r.f0), 32'(e0));
      check({tag, "_ch1"}, 32'(r.f1), 32'(e1));
      check({tag, "_synclen"}, 32'(r.len), 32'(16 * CD));
      check({tag, "_falls"}, 32'(r.falls), 32'd16);
      check({tag, "_done"}, 32'(r.done), 32'd1);
    end
  endtask

  initial begin
    vec_t        vecs[5];
    logic [15:0] d;
    logic [1:0]  pd;
    logic [7:0]  b2b_vals[3];
    int          acc_n;
    int          snap[3];
    int          k;

    vecs[0] = '{d: 16'h3CA5, pd: 2'b00, e0: 16'h0A50, e1: 16'h03C0};
    vecs[1] = '{d: 16'hFF01, pd: 2'b00, e0: 16'h0010, e1: 16'h0FF0};
    vecs[2] = '{d: 16'h0000, pd: 2'b11, e0: 16'h3000, e1: 16'h3000};
    vecs[3] = '{d: 16'h807F, pd: 2'b01, e0: 16'h17F0, e1: 16'h1800};
    vecs[4] = '{d: 16'hC35A, pd: 2'b10, e0: 16'h25A0, e1: 16'h2C30};

    // Reset held with s_valid high.
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = '0;
    s_pd    = 2'b00;
    repeat (4) @(negedge clk);
    check("rst_sync", 32'(SYNC), 32'd1);
    check("rst_sclk", 32'(SCLK), 32'd1);
    check("rst_data", 32'(DATA), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_first_edge", 32'(s_ready), 32'd1);
    check("no_accept_first_edge", 32'(SYNC), 32'd1);
    s_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].d, vecs[i].pd);
      check_frame($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1);
    end

    for (int i = 0; i < 6; i++) begin
      d  = 16'($urandom);
      pd = 2'($urandom_range(3));
      send(d, pd);
      check_frame($sformatf("rand%0d", i), model_frame(pd, int'(d) % 256), model_frame(pd, int'(d) / 256));
    end

    // Back-to-back with s_valid held high.
    b2b_vals[0] = 8'h10;
    b2b_vals[1] = 8'h20;
    b2b_vals[2] = 8'h30;
    @(posedge clk);
    #1;
    sync_fall_q.delete();
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = {b2b_vals[0], b2b_vals[0]};
    s_pd    = 2'b00;
    acc_n   = 0;
    for (k = 0; k < 400 && acc_n < 3; k++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        #1;
        snap[acc_n] = rdy_cnt;
        acc_n++;
        if (acc_n < 3) s_data = {b2b_vals[acc_n], b2b_vals[acc_n]};
        else s_valid = 1'b0;
      end
    end
    check("b2b_accepts", 32'(acc_n), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check_frame($sformatf("b2b%0d", i), model_frame(2'b00, int'(b2b_vals[i])),
                  model_frame(2'b00, int'(b2b_vals[i])));
    end
    if (sync_fall_q.size() >= 3) begin
      check("b2b_space01", 32'(sync_fall_q[1] - sync_fall_q[0]), 32'(16 * CD + GC + 1));
      check("b2b_space12", 32'(sync_fall_q[2] - sync_fall_q[1]), 32'(16 * CD + GC + 1));
    end else begin
      check("b2b_sync_falls", 32'(sync_fall_q.size()), 32'd3);
    end
    if (acc_n == 3) check("b2b_ready_cycles", 32'(snap[2] - snap[0]), 32'd2);

    // Reset after the fifth SCLK falling edge, then a clean frame.
    send(16'h005A, 2'b00);
    for (k = 0; k < 200; k++) begin
      if (m_falls >= 5) break;
      @(posedge clk);
      #1;
    end
    check("mid_falls_reached", 32'(m_falls >= 5), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sync", 32'(SYNC), 32'd1);
    check("mid_rst_sclk", 32'(SCLK), 32'd1);
    check("mid_rst_data", 32'(DATA), 32'd0);
    check("mid_rst_ready", 32'(s_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("mid_no_partial_frame", 32'(mon_q.size()), 32'd0);
    send(16'hFFFF, 2'b00);
    check_frame("after_rst", 16'h0FF0, 16'h0FF0);

    repeat (10) @(posedge clk);
    #1;
    check("done_pulse_count", 32'(done_cnt), 32'(frames_seen));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
